muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        start,
   input  logic [4:0]  Opcode,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic        busy,
   output logic        valid,
   output logic [31:0] result
);

   localparam logic [4:0] OP_MUL    = 5'b00100;
   localparam logic [4:0] OP_MULH   = 5'b00101;
   localparam logic [4:0] OP_MULHU  = 5'b00110;
   localparam logic [4:0] OP_MULHSU = 5'b00111;
   localparam logic [4:0] OP_DIV    = 5'b01000;
   localparam logic [4:0] OP_DIVU   = 5'b01001;
   localparam logic [4:0] OP_REM    = 5'b01010;
   localparam logic [4:0] OP_REMU   = 5'b01011;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   logic [4:0]  op_q;
   logic [4:0]  cnt;
   logic        neg_q;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] opb;

   logic        supported, a_signed, b_signed, is_div, special, neg_in;
   logic [31:0] a_mag, b_mag, special_res;

   always_comb begin
      supported   = (Opcode >= OP_MUL) && (Opcode <= OP_REMU);
      is_div      = Opcode[3];
      a_signed    = (Opcode == OP_MULH) || (Opcode == OP_MULHSU) ||
                    (Opcode == OP_DIV)  || (Opcode == OP_REM);
      b_signed    = (Opcode == OP_MULH) || (Opcode == OP_DIV) || (Opcode == OP_REM);
      a_mag       = (a_signed && data1[31]) ? -data1 : data1;
      b_mag       = (b_signed && data2[31]) ? -data2 : data2;
      special     = 1'b0;
      special_res = 32'h0;
      if (is_div && data2 == 32'h0) begin
         special     = 1'b1;
         special_res = (Opcode == OP_DIV || Opcode == OP_DIVU) ? 32'hFFFF_FFFF : data1;
      end else if ((Opcode == OP_DIV || Opcode == OP_REM) &&
                   data1 == 32'h8000_0000 && data2 == 32'hFFFF_FFFF) begin
         special     = 1'b1;
         special_res = (Opcode == OP_DIV) ? 32'h8000_0000 : 32'h0;
      end
      // Remainder follows the dividend sign; quotient/product follow the sign xor
      if (Opcode == OP_REM)
         neg_in = data1[31];
      else
         neg_in = (a_signed & data1[31]) ^ (b_signed & data2[31]);
   end

   logic [63:0] acc_nx, mcand_nx, prod;
   logic [31:0] opb_nx, quot, rem, final_res;
   logic [32:0] rem_sh, diff;

   always_comb begin
      mcand_nx = mcand;
      rem_sh   = {acc[31:0], opb[31]};
      diff     = rem_sh - {1'b0, mcand[31:0]};
      if (op_q[3]) begin
         // Restoring step: dividend bits shift out of opb, quotient bits shift in
         if (!diff[32]) begin
            acc_nx = {31'b0, diff};
            opb_nx = {opb[30:0], 1'b1};
         end else begin
            acc_nx = {31'b0, rem_sh};
            opb_nx = {opb[30:0], 1'b0};
         end
      end else begin
         acc_nx   = acc + (opb[0] ? mcand : 64'h0);
         mcand_nx = {mcand[62:0], 1'b0};
         opb_nx   = {1'b0, opb[31:1]};
      end
      prod = neg_q ? -acc_nx : acc_nx;
      quot = neg_q ? -opb_nx : opb_nx;
      rem  = neg_q ? -acc_nx[31:0] : acc_nx[31:0];
      case (op_q)
         OP_MUL:                      final_res = prod[31:0];
         OP_MULH, OP_MULHU, OP_MULHSU: final_res = prod[63:32];
         OP_DIV, OP_DIVU:             final_res = quot;
         default:                     final_res = rem;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state  <= IDLE;
         busy   <= 1'b0;
         valid  <= 1'b0;
         result <= 32'h0;
         op_q   <= 5'h0;
         cnt    <= 5'h0;
         neg_q  <= 1'b0;
         acc    <= 64'h0;
         mcand  <= 64'h0;
         opb    <= 32'h0;
      end else if (state != CALC && start && supported) begin
         op_q  <= Opcode;
         neg_q <= neg_in;
         cnt   <= 5'h0;
         acc   <= 64'h0;
         mcand <= {32'h0, is_div ? b_mag : a_mag};
         opb   <= is_div ? a_mag : b_mag;
         if (special) begin
            state  <= DONE;
            busy   <= 1'b0;
            valid  <= 1'b1;
            result <= special_res;
         end else begin
            state <= CALC;
            busy  <= 1'b1;
            valid <= 1'b0;
         end
      end else begin
         case (state)
            CALC: begin
               acc   <= acc_nx;
               mcand <= mcand_nx;
               opb   <= opb_nx;
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  valid  <= 1'b1;
                  result <= final_res;
               end
            end
            DONE: begin
               state <= IDLE;
               valid <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  Opcode = 5'h0;
   logic [31:0] data1 = 32'h0;
   logic [31:0] data2 = 32'h0;
   logic        busy, valid;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   muldiv_unit dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .Opcode(Opcode),
      .data1(data1), .data2(data2), .busy(busy), .valid(valid), .result(result)
   );

   always #5 CLK = ~CLK;

   // Monitor: every valid strobe must match the oldest outstanding expectation
   always @(negedge CLK) begin
      if (valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: result=%h, no result outstanding", result);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (result !== e) begin
               n_err++;
               $display("FAIL result: got %h, required %h", result, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k, bc;
      @(negedge CLK);
      start = 1'b1; Opcode = op; data1 = a; data2 = b;
      exp_q.push_back(exp);
      @(posedge CLK); #1;
      start = 1'b0;
      k = 0; bc = 0;
      while (!valid && k < 40) begin
         if (busy) bc++;
         @(posedge CLK); #1;
         k++;
      end
      n_vec++;
      if (k != lat || bc != lat) begin
         n_err++;
         $display("FAIL timing_%s: cycles=%0d busy_cycles=%0d, required %0d", name, k, bc, lat);
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      int k;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_busy",   {31'b0, busy},  32'h0);
      check("reset_valid",  {31'b0, valid}, 32'h0);
      check("reset_result", result,         32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;

      run_op("mul",     5'b00100, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
      run_op("mulhu",   5'b00110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      run_op("mulh",    5'b00101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32);
      run_op("mulhsu",  5'b00111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      run_op("div",     5'b01000, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
      run_op("rem",     5'b01010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
      run_op("divu",    5'b01001, 32'd100,       32'd7,         32'd14,        32);
      run_op("remu",    5'b01011, 32'd100,       32'd7,         32'd2,         32);
      run_op("divu_z",  5'b01001, 32'd100,       32'd0,         32'hFFFF_FFFF, 0);
      run_op("remu_z",  5'b01011, 32'd100,       32'd0,         32'd100,       0);
      run_op("div_ovf", 5'b01000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ovf", 5'b01010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

      // Unsupported opcode: no activity, result holds
      @(negedge CLK);
      start = 1'b1; Opcode = 5'b00000; data1 = 32'd5; data2 = 32'd6;
      @(posedge CLK); #1;
      start = 1'b0;
      check("unsup_busy",   {31'b0, busy}, 32'h0);
      check("unsup_result", result,        32'h0);

      // Start while busy is ignored
      @(negedge CLK);
      start = 1'b1; Opcode = 5'b00100; data1 = 32'd3; data2 = 32'd5;
      exp_q.push_back(32'd15);
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      start = 1'b1; Opcode = 5'b01001; data1 = 32'd9; data2 = 32'd3;
      @(posedge CLK); #1;
      start = 1'b0;
      k = 10;
      while (!valid && k < 45) begin
         @(posedge CLK); #1;
         k++;
      end
      check("busy_start_latency", k, 32);
      repeat (40) @(posedge CLK);

      // Reset mid-operation, with a start sampled on the reset edge
      @(negedge CLK);
      start = 1'b1; Opcode = 5'b01000; data1 = 32'd100; data2 = 32'd7;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (11) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0; start = 1'b1; Opcode = 5'b00100; data1 = 32'd9; data2 = 32'd9;
      @(posedge CLK); #1;
      start = 1'b0;
      check("rst_busy",   {31'b0, busy},  32'h0);
      check("rst_valid",  {31'b0, valid}, 32'h0);
      check("rst_result", result,         32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK); #1;
      check("rst_start_ignored", {31'b0, busy}, 32'h0);
      repeat (40) @(posedge CLK);

      run_op("mul_after_rst", 5'b00100, 32'd2, 32'd2, 32'd4, 32);
      repeat (5) @(posedge CLK);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
